// File: rtl/sample_row_writer_pkg.sv
// Shared definitions for the flicker-fixer row writer: row geometry,
// default SDRAM burst size and the writer state encoding.
package sample_row_writer_pkg;

  localparam int ROW_WORDS         = 640;
  localparam int BURST_LEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    REQ,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/row_prefetch_fifo.sv
// Two-entry prefetch FIFO between the line-cache read pipeline and the
// SDRAM write stream. A push and a pop in the same cycle leave the
// occupancy unchanged, so one word per cycle can flow through it.
module row_prefetch_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  // Word storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/sample_row_writer.sv
// Copies one 640-word line-cache row into SDRAM as a sequence of write
// bursts. Requests arrive as a toggle handshake from the frame sampler;
// line-cache reads run ahead of the burst stream through a 2-entry FIFO.
// wb_req rises three clocks after the edge that accepts a request.
module sample_row_writer
  import sample_row_writer_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_req,
  output logic        s_ack,
  input  logic        s_cache_row,
  input  logic [9:0]  s_sdram_row,
  output logic [10:0] rd_address,
  input  logic [15:0] rd_data,
  output logic        wb_req,
  input  logic        wb_gnt,
  output logic [19:0] wb_addr,
  output logic [15:0] wb_data,
  input  logic        wb_data_rd,
  output logic        row_overrun
);

  localparam logic [9:0] LP_ROW   = 10'(ROW_WORDS);
  localparam logic [9:0] LP_BURST = 10'(BURST_LEN);
  localparam logic [9:0] LP_LAST  = 10'(BURST_LEN - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_cache_row;
  logic [9:0]  r_sdram_row;
  logic [9:0]  r_rd_col;
  logic [9:0]  r_words_wr;
  logic [9:0]  r_wr_base;
  logic [9:0]  r_burst_pops;
  logic        r_inflight;
  logic        r_ack;
  logic        r_overrun;

  logic        w_accept;
  logic        w_active;
  logic        w_pop;
  logic        w_issue;
  logic        w_last_pop;
  logic [2:0]  w_occ_after;
  logic [1:0]  w_fifo_count;
  logic [15:0] w_fifo_head;

  assign w_accept   = (r_state == IDLE) && (s_req != r_ack);
  assign w_active   = (r_state == PREFETCH) || (r_state == REQ) || (r_state == STREAM);
  // A pop is only honoured inside a granted burst and never past its length.
  assign w_pop      = (r_state == STREAM) && wb_data_rd && (r_burst_pops < LP_BURST)
                      && (w_fifo_count != 2'd0);
  // Occupancy this cycle ends with: current - pop + the word arriving now.
  assign w_occ_after = {1'b0, w_fifo_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue    = w_active && (w_occ_after < 3'd2) && (r_rd_col < LP_ROW);
  assign w_last_pop = w_pop && (r_burst_pops == LP_LAST);

  assign rd_address  = {r_cache_row, r_rd_col};
  assign wb_addr     = {r_sdram_row, r_wr_base};
  assign s_ack       = r_ack;
  assign row_overrun = r_overrun;

  row_prefetch_fifo #(
    .DATA_W (16)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_data  (rd_data),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  // State register; reset returns to IDLE immediately, even mid-burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and burst-side outputs.
  always_comb begin
    w_next  = r_state;
    wb_req  = 1'b0;
    wb_data = '0;
    case (r_state)
      IDLE:     if (w_accept) w_next = PREFETCH;
      PREFETCH: if (w_occ_after == 3'd2) w_next = REQ;
      REQ: begin
        wb_req = 1'b1;
        if (wb_gnt) w_next = STREAM;
      end
      STREAM: begin
        wb_data = w_fifo_head;
        if (w_last_pop) w_next = ((r_words_wr + 10'd1) == LP_ROW) ? DONE : REQ;
      end
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Row latches, read/write counters and the read pipeline flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cache_row  <= 1'b0;
      r_sdram_row  <= '0;
      r_rd_col     <= '0;
      r_words_wr   <= '0;
      r_wr_base    <= '0;
      r_burst_pops <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_cache_row  <= s_cache_row;
        r_sdram_row  <= s_sdram_row;
        r_rd_col     <= '0;
        r_words_wr   <= '0;
        r_wr_base    <= '0;
        r_burst_pops <= '0;
      end else begin
        if (w_issue) r_rd_col <= r_rd_col + 10'd1;
        if (w_pop) begin
          r_words_wr <= r_words_wr + 10'd1;
          if (w_last_pop) begin
            r_burst_pops <= '0;
            r_wr_base    <= r_words_wr + 10'd1;
          end else begin
            r_burst_pops <= r_burst_pops + 10'd1;
          end
        end
      end
    end
  end

  // Handshake acknowledge and the sticky cache-row overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == DONE) r_ack <= s_req;
      if ((r_state != IDLE) && (s_cache_row != r_cache_row)) r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_row_writer.sv
// Bench for sample_row_writer: line-cache model, SDRAM controller model
// with configurable grant delay and read duty, and a scoreboard of
// expected burst addresses and data words filled when a row is requested.
`timescale 1ns/1ps
module tb_sample_row_writer;
  import sample_row_writer_pkg::*;

  localparam int BL = 64;
  localparam int NB = ROW_WORDS / BL;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_req;
  logic        s_ack;
  logic        s_cache_row;
  logic [9:0]  s_sdram_row;
  logic [10:0] rd_address;
  logic [15:0] rd_data;
  logic        wb_req;
  logic        wb_gnt;
  logic [19:0] wb_addr;
  logic [15:0] wb_data;
  logic        wb_data_rd;
  logic        row_overrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [19:0] addr_q[$];

  typedef struct {
    bit         toggle;
    bit         cache_row;
    logic [9:0] sdram_row;
    int         duty;
    int         gnt_max;
    int         flip_at;
    int         reset_at;
    bit         exp_ovr;
  } row_vec_t;

  row_vec_t vecs[6];

  sample_row_writer #(.BURST_LEN(BL)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_req       (s_req),
    .s_ack       (s_ack),
    .s_cache_row (s_cache_row),
    .s_sdram_row (s_sdram_row),
    .rd_address  (rd_address),
    .rd_data     (rd_data),
    .wb_req      (wb_req),
    .wb_gnt      (wb_gnt),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_data_rd  (wb_data_rd),
    .row_overrun (row_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cache_word(input logic row, input logic [9:0] col);
    return {row, ~col[4:0], col};
  endfunction

  // Line cache: synchronous read, data valid the cycle after the address.
  always_ff @(posedge clk) rd_data <= cache_word(rd_address[10], rd_address[9:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic noise(input int duty);
    return (duty < 100) ? logic'($urandom_range(1, 0)) : 1'b0;
  endfunction

  task automatic run_row(input row_vec_t v, output bit aborted);
    int  words, lat, cyc, n, dly;
    bit  rd;
    aborted = 1'b0;
    for (int c = 0; c < ROW_WORDS; c++) exp_q.push_back(cache_word(v.cache_row, 10'(c)));
    for (int b = 0; b < NB; b++) addr_q.push_back({v.sdram_row, 10'(b * BL)});
    s_cache_row = v.cache_row;
    s_sdram_row = v.sdram_row;
    if (v.toggle) s_req = ~s_req;
    words = 0;
    for (int b = 0; b < NB; b++) begin
      lat = 0;
      while (!wb_req && lat < 60) begin
        wb_data_rd = noise(v.duty);
        @(negedge clk);
        lat++;
      end
      wb_data_rd = 1'b0;
      if (!wb_req) begin fail("wb_req_wait"); aborted = 1'b1; return; end
      if (b == 0) check("req_latency", lat, 4);
      check("wb_addr", wb_addr, addr_q.pop_front());
      dly = int'($urandom_range(v.gnt_max, 0));
      for (int d = 0; d < dly; d++) begin
        wb_data_rd = noise(v.duty);
        @(negedge clk);
        check("req_hold", wb_req, 1);
      end
      wb_gnt     = 1'b1;
      wb_data_rd = noise(v.duty);
      @(negedge clk);
      wb_gnt     = 1'b0;
      wb_data_rd = 1'b0;
      check("req_drop", wb_req, 0);
      n = 0;
      cyc = 0;
      while (n < BL && cyc < 5000) begin
        rd = ($urandom_range(99, 0) < v.duty);
        wb_data_rd = rd;
        if (rd) begin
          check("wb_data", wb_data, exp_q.pop_front());
          n++;
          words++;
        end
        @(negedge clk);
        cyc++;
        wb_data_rd = 1'b0;
        if (rd && words == v.flip_at) begin
          s_cache_row = ~v.cache_row;
          s_sdram_row = ~v.sdram_row;
        end
        if (rd && words == v.reset_at) begin
          reset_n = 1'b0;
          #1;
          check("rst_wb_req", wb_req, 0);
          check("rst_s_ack", s_ack, 0);
          check("rst_rd_address", rd_address, 0);
          check("rst_wb_addr", wb_addr, 0);
          check("rst_wb_data", wb_data, 0);
          aborted = 1'b1;
          return;
        end
      end
      if (n < BL) begin fail("stream_wait"); aborted = 1'b1; return; end
    end
    cyc = 0;
    while (s_ack !== s_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("s_ack", s_ack, s_req);
    check("ack_timing", cyc, 1);
    check("idle_wb_req", wb_req, 0);
    check("row_overrun", row_overrun, v.exp_ovr);
  endtask

  initial begin
    bit aborted;
    reset_n     = 1'b0;
    s_req       = 1'b0;
    s_cache_row = 1'b0;
    s_sdram_row = '0;
    wb_gnt      = 1'b0;
    wb_data_rd  = 1'b0;

    //        toggle cr  sdram    duty gnt flip reset ovr
    vecs[0] = '{1'b1, 1'b1, 10'h155, 100, 0,  -1,  -1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 10'h2AA, 30,  20, -1,  -1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 10'h013, 100, 3,  -1, 300, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 10'h013, 60,  5,  -1,  -1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 10'h3FF, 100, 0,  -1,  -1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 10'h0C3, 50,  2,  100, -1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_s_ack", s_ack, 0);
    check("reset_wb_req", wb_req, 0);
    check("reset_rd_address", rd_address, 0);
    check("reset_wb_addr", wb_addr, 0);
    check("reset_wb_data", wb_data, 0);
    check("reset_row_overrun", row_overrun, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_request", wb_req, 0);

    for (int i = 0; i < 6; i++) begin
      run_row(vecs[i], aborted);
      if (aborted) begin
        exp_q.delete();
        addr_q.delete();
        wb_gnt     = 1'b0;
        wb_data_rd = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
